// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and field-position helpers for the multicycle control FSM.
// Instruction layout (LSB first): fmt[1:0], op[4:2], imm[..:5], then rs and rd at the top.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_STORE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FMT_R    = 2'b00,
    FMT_I    = 2'b01,
    FMT_MOVI = 2'b10,
    FMT_ILL  = 2'b11
  } fmt_e;

  localparam int FMT_LSB = 0;
  localparam int OP_LSB  = 2;
  localparam int IMM_LSB = 5;

  function automatic int rd_msb(input int instr_w);
    return instr_w - 1;
  endfunction

  function automatic int rs_msb(input int instr_w, input int reg_aw);
    return instr_w - reg_aw - 1;
  endfunction

  function automatic int imm_width(input int instr_w, input int reg_aw);
    return instr_w - reg_aw - 5;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-source / datapath-control bundle of the multicycle controller.
// master = instruction source, slave = the controller.
interface multicycle_ctrl_if #(
  parameter int DATA_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
);
  localparam int REG_AW = $clog2(NUM_REGS);

  logic                start;
  logic [INSTR_W-1:0]  instruction;
  logic                hold;
  logic                en_i;
  logic                en_s;
  logic                en_c;
  logic [NUM_REGS-1:0] reg_en;
  logic [2:0]          alu_sel;
  logic [REG_AW:0]     mux_sel;
  logic [DATA_W-1:0]   imm_val;
  logic                busy;
  logic                done;
  logic                illegal;
  logic [CNT_W-1:0]    retired_cnt;

  modport master (
    output start, instruction, hold,
    input  en_i, en_s, en_c, reg_en, alu_sel, mux_sel, imm_val,
           busy, done, illegal, retired_cnt
  );

  modport slave (
    input  start, instruction, hold,
    output en_i, en_s, en_c, reg_en, alu_sel, mux_sel, imm_val,
           busy, done, illegal, retired_cnt
  );

endinterface

// File: rtl/multicycle_ctrl_dec.sv
// Combinational decode of the latched instruction: field extract,
// immediate extension and one-hot destination register select.
module multicycle_ctrl_dec
  import multicycle_ctrl_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int INSTR_W      = 16,
  parameter int NUM_REGS     = 8,
  parameter int SIGN_EXT_IMM = 0
) (
  input  logic [INSTR_W-1:0]            ir,
  output fmt_e                          fmt,
  output logic [2:0]                    op,
  output logic [$clog2(NUM_REGS)-1:0]   rd,
  output logic [$clog2(NUM_REGS)-1:0]   rs,
  output logic [DATA_W-1:0]             imm_ext,
  output logic [NUM_REGS-1:0]           rd_onehot
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int RD_MSB = rd_msb(INSTR_W);
  localparam int RS_MSB = rs_msb(INSTR_W, REG_AW);
  localparam int IMM_W  = imm_width(INSTR_W, REG_AW);

  logic [IMM_W-1:0] imm;

  assign fmt = fmt_e'(ir[FMT_LSB +: 2]);
  assign op  = ir[OP_LSB +: 3];
  assign rd  = ir[RD_MSB -: REG_AW];
  assign rs  = ir[RS_MSB -: REG_AW];
  assign imm = ir[RS_MSB:IMM_LSB];

  // Bit-wise extension keeps this legal when IMM_W == DATA_W (no zero-width replication).
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    imm_ext            = '0;
    imm_ext[IMM_W-1:0] = imm;
    for (int i = IMM_W; i < DATA_W; i++) begin
      imm_ext[i] = (SIGN_EXT_IMM != 0) & imm[IMM_W-1];
    end
  end

  assign rd_onehot = NUM_REGS'(1) << rd;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (FETCH/LOAD/EXEC/STORE) with start/busy/done handshake,
// instruction register, stall input and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int         DATA_W       = 16,
  parameter int         INSTR_W      = 16,
  parameter int         NUM_REGS     = 8,
  parameter int         CNT_W        = 16,
  parameter int         SIGN_EXT_IMM = 0,
  parameter logic [2:0] PASS_B_OP    = 3'b111
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.slave bus
);
  localparam int              REG_AW   = $clog2(NUM_REGS);
  localparam logic [REG_AW:0] MUX_IDLE = '1;
  localparam logic [REG_AW:0] MUX_IMM  = {1'b1, {REG_AW{1'b0}}};

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 accept;
  logic                 retire;

  fmt_e                 fmt;
  logic [2:0]           op;
  logic [REG_AW-1:0]    rd;
  logic [REG_AW-1:0]    rs;
  logic [DATA_W-1:0]    imm_ext;
  logic [NUM_REGS-1:0]  rd_onehot;

  multicycle_ctrl_dec #(
    .DATA_W       (DATA_W),
    .INSTR_W      (INSTR_W),
    .NUM_REGS     (NUM_REGS),
    .SIGN_EXT_IMM (SIGN_EXT_IMM)
  ) u_dec (
    .ir        (ir_q),
    .fmt       (fmt),
    .op        (op),
    .rd        (rd),
    .rs        (rs),
    .imm_ext   (imm_ext),
    .rd_onehot (rd_onehot)
  );

  // STORE accepts a new request directly so back-to-back instructions have no bubble.
  assign accept = bus.start && !bus.hold && (state_q == S_IDLE || state_q == S_STORE);
  assign retire = (state_q == S_STORE) && !bus.hold && (fmt != FMT_ILL);

  // NOTE: reset is synchronous, so it is simply the first branch inside the clocked block;
  // the IR is a plain register and is cleared with the rest of the state.
  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) ir_q  <= bus.instruction;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.hold) begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_FETCH;
        S_FETCH: begin
          case (fmt)
            FMT_R, FMT_I: state_d = S_LOAD;
            FMT_MOVI:     state_d = S_EXEC;
            default:      state_d = S_STORE;
          endcase
        end
        S_LOAD:  state_d = S_EXEC;
        S_EXEC:  state_d = S_STORE;
        S_STORE: state_d = accept ? S_FETCH : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs from state + IR; hold masks the one-shot strobes, reset masks everything.
  always_comb begin
    bus.en_i    = 1'b0;
    bus.en_s    = 1'b0;
    bus.en_c    = 1'b0;
    bus.reg_en  = '0;
    bus.alu_sel = '0;
    bus.mux_sel = MUX_IDLE;
    bus.imm_val = '0;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    case (state_q)
      S_FETCH: bus.en_i = 1'b1;
      S_LOAD: begin
        bus.en_s    = 1'b1;
        bus.mux_sel = {1'b0, rd};
      end
      S_EXEC: begin
        bus.en_c    = 1'b1;
        bus.alu_sel = (fmt == FMT_MOVI) ? PASS_B_OP : op;
        if (fmt == FMT_R) begin
          bus.mux_sel = {1'b0, rs};
        end else begin
          bus.mux_sel = MUX_IMM;
          bus.imm_val = imm_ext;
        end
      end
      S_STORE: begin
        bus.done = 1'b1;
        if (fmt == FMT_ILL) bus.illegal = 1'b1;
        else                bus.reg_en  = rd_onehot;
      end
      default: ;
    endcase
    if (bus.hold) begin
      bus.en_i    = 1'b0;
      bus.en_s    = 1'b0;
      bus.en_c    = 1'b0;
      bus.reg_en  = '0;
      bus.done    = 1'b0;
      bus.illegal = 1'b0;
    end
    if (reset) begin
      bus.en_i    = 1'b0;
      bus.en_s    = 1'b0;
      bus.en_c    = 1'b0;
      bus.reg_en  = '0;
      bus.alu_sel = '0;
      bus.mux_sel = MUX_IDLE;
      bus.imm_val = '0;
      bus.done    = 1'b0;
      bus.illegal = 1'b0;
    end
  end

  assign bus.busy        = (state_q != S_IDLE) && !reset;
  assign bus.retired_cnt = reset ? '0 : cnt_q;

endmodule
